// File: rtl/rom_port_arbiter.sv
// Shares one combinational instruction ROM between the fetch port and a load port.
// One grant per cycle; registered, checked and size-extracted responses one cycle later.
module rom_port_arbiter #(
  parameter int ROM_BYTES  = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic        ld_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_reg;
  logic [31:0]   addr_hold_reg;
  logic          fetch_prio;
  logic          if_bad;
  logic          ld_bad;
  logic [2:0]    ld_bytes;
  logic [32:0]   ld_end;
  logic [31:0]   ld_data;

  assign fetch_prio = (starve_cnt_reg == CW'(STARVE_MAX));

  // Load normally wins; a fetch starved for STARVE_MAX cycles takes the slot.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst) begin
      if (if_req && (fetch_prio || !ld_req)) begin
        if_gnt = 1'b1;
      end else if (ld_req) begin
        ld_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rom_addr = addr_hold_reg;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (ld_gnt) begin
      rom_addr = ld_addr;
    end
  end

  assign if_bad = (if_addr[1:0] != 2'b00) || (if_addr > 32'(ROM_BYTES - 4));

  always_comb begin
    ld_bytes = 3'd1;
    case (ld_size)
      2'b01:   ld_bytes = 3'd2;
      2'b10:   ld_bytes = 3'd4;
      default: ld_bytes = 3'd1;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign ld_end = {1'b0, ld_addr} + 33'(ld_bytes);

  assign ld_bad = (ld_size == 2'b11)
               || ((ld_size == 2'b01) && ld_addr[0])
               || ((ld_size == 2'b10) && (ld_addr[1:0] != 2'b00))
               || (ld_end > 33'(ROM_BYTES));

  // ROM data is big-endian from the addressed byte, so narrow loads take the top bits.
  always_comb begin
    ld_data = rom_data;
    case (ld_size)
      2'b00:   ld_data = {{24{ld_signed & rom_data[31]}}, rom_data[31:24]};
      2'b01:   ld_data = {{16{ld_signed & rom_data[31]}}, rom_data[31:16]};
      default: ld_data = rom_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      addr_hold_reg  <= '0;
      if_rvalid      <= 1'b0;
      if_rdata       <= '0;
      if_err         <= 1'b0;
      ld_rvalid      <= 1'b0;
      ld_rdata       <= '0;
      ld_err         <= 1'b0;
    end else begin
      if (if_req && !if_gnt && !fetch_prio) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end else begin
        starve_cnt_reg <= '0;
      end

      addr_hold_reg <= rom_addr;

      if_rvalid <= if_gnt;
      if_err    <= if_gnt && if_bad;
      if (if_gnt) begin
        if_rdata <= if_bad ? 32'd0 : rom_data;
      end

      ld_rvalid <= ld_gnt;
      ld_err    <= ld_gnt && ld_bad;
      if (ld_gnt) begin
        ld_rdata <= ld_bad ? 32'd0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: driver pushes expected responses, monitor pops and compares.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t if_q[$];
  resp_t ld_q[$];

  logic [7:0] rom_mem [0:255];

  always #5 clk = ~clk;

  rom_port_arbiter #(.ROM_BYTES(256), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    if (a < 32'd256) return rom_mem[a[7:0]];
    return 8'h00;
  endfunction

  assign rom_data = {rom_byte(rom_addr), rom_byte(rom_addr + 32'd1),
                     rom_byte(rom_addr + 32'd2), rom_byte(rom_addr + 32'd3)};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One grant-cycle transaction: check grants at the falling edge and queue the response.
  task automatic step(input string tag, input logic eig, input logic elg,
                      input logic [31:0] eaddr, input logic [31:0] edata, input logic eerr);
    resp_t r;
    @(negedge clk);
    chk({tag, " if_gnt"}, {31'd0, if_gnt}, {31'd0, eig});
    chk({tag, " ld_gnt"}, {31'd0, ld_gnt}, {31'd0, elg});
    r.data = edata;
    r.err  = eerr;
    if (eig || elg) chk({tag, " rom_addr"}, rom_addr, eaddr);
    if (eig) if_q.push_back(r);
    if (elg) ld_q.push_back(r);
    $display("txn %-12s if_gnt=%0b ld_gnt=%0b rom_addr=%h exp_data=%h exp_err=%0b",
             tag, if_gnt, ld_gnt, rom_addr, edata, eerr);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (if_rvalid === 1'b1) begin
        if (if_q.size() == 0) begin
          chk("if unexpected rvalid", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = if_q.pop_front();
          chk("if_rdata", if_rdata, r.data);
          chk("if_err", {31'd0, if_err}, {31'd0, r.err});
        end
      end
      if (ld_rvalid === 1'b1) begin
        if (ld_q.size() == 0) begin
          chk("ld unexpected rvalid", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = ld_q.pop_front();
          chk("ld_rdata", ld_rdata, r.data);
          chk("ld_err", {31'd0, ld_err}, {31'd0, r.err});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_ld(input logic req, input logic [31:0] a, input logic [1:0] s, input logic sg);
    ld_req = req; ld_addr = a; ld_size = s; ld_signed = sg;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
    rom_mem[8'h00] = 8'h03; rom_mem[8'h01] = 8'h20; rom_mem[8'h02] = 8'h00; rom_mem[8'h03] = 8'h93;
    rom_mem[8'h04] = 8'h00; rom_mem[8'h05] = 8'h00; rom_mem[8'h06] = 8'h00; rom_mem[8'h07] = 8'h33;
    rom_mem[8'h14] = 8'hfe; rom_mem[8'h15] = 8'h11; rom_mem[8'h16] = 8'h4c; rom_mem[8'h17] = 8'he3;

    // Reset held two cycles with both requests active.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    set_ld(1'b1, 32'h4, 2'b10, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst ld_gnt", {31'd0, ld_gnt}, 32'd0);
      chk("rst if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
      chk("rst if_err", {31'd0, if_err}, 32'd0);
      chk("rst ld_err", {31'd0, ld_err}, 32'd0);
      chk("rst if_rdata", if_rdata, 32'd0);
      chk("rst ld_rdata", ld_rdata, 32'd0);
      chk("rst rom_addr", rom_addr, 32'd0);
      $display("txn reset cycle %0d", c);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; if_req = 1'b0; ld_req = 1'b0;
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Single fetch.
    if_req = 1'b1; if_addr = 32'h0;
    step("fetch0", 1'b1, 1'b0, 32'h0, 32'h03200093, 1'b0);
    if_req = 1'b0;
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Simultaneous: load first, fetch next cycle.
    if_req = 1'b1; if_addr = 32'h0;
    set_ld(1'b1, 32'h4, 2'b10, 1'b0);
    step("both_ld", 1'b0, 1'b1, 32'h4, 32'h00000033, 1'b0);
    ld_req = 1'b0;
    step("both_if", 1'b1, 1'b0, 32'h0, 32'h03200093, 1'b0);
    if_req = 1'b0;

    // Starvation: fetch wins on the fifth contended cycle.
    if_req = 1'b1; if_addr = 32'h4;
    set_ld(1'b1, 32'h4, 2'b10, 1'b0);
    for (int c = 0; c < 4; c++) step("starve_ld", 1'b0, 1'b1, 32'h4, 32'h00000033, 1'b0);
    step("starve_if", 1'b1, 1'b0, 32'h4, 32'h00000033, 1'b0);
    if_req = 1'b0;
    step("after_ld", 1'b0, 1'b1, 32'h4, 32'h00000033, 1'b0);
    if_req = 1'b1;
    step("regain_ld", 1'b0, 1'b1, 32'h4, 32'h00000033, 1'b0);
    if_req = 1'b0; ld_req = 1'b0;
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rom_addr hold", rom_addr, 32'h4);

    // Extraction at 0x14, back to back.
    set_ld(1'b1, 32'h14, 2'b00, 1'b1);
    step("ld_b_s", 1'b0, 1'b1, 32'h14, 32'hfffffffe, 1'b0);
    set_ld(1'b1, 32'h14, 2'b00, 1'b0);
    step("ld_b_u", 1'b0, 1'b1, 32'h14, 32'h000000fe, 1'b0);
    set_ld(1'b1, 32'h14, 2'b01, 1'b0);
    step("ld_h_u", 1'b0, 1'b1, 32'h14, 32'h0000fe11, 1'b0);
    set_ld(1'b1, 32'h14, 2'b01, 1'b1);
    step("ld_h_s", 1'b0, 1'b1, 32'h14, 32'hfffffe11, 1'b0);
    set_ld(1'b1, 32'h14, 2'b10, 1'b0);
    step("ld_w", 1'b0, 1'b1, 32'h14, 32'hfe114ce3, 1'b0);
    ld_req = 1'b0;
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("ld_rdata hold", ld_rdata, 32'hfe114ce3);

    // Error and boundary cases.
    set_ld(1'b1, 32'h2, 2'b10, 1'b0);
    step("ld_w_mis", 1'b0, 1'b1, 32'h2, 32'h0, 1'b1);
    set_ld(1'b1, 32'h15, 2'b01, 1'b0);
    step("ld_h_mis", 1'b0, 1'b1, 32'h15, 32'h0, 1'b1);
    set_ld(1'b1, 32'h14, 2'b11, 1'b0);
    step("ld_rsvd", 1'b0, 1'b1, 32'h14, 32'h0, 1'b1);
    set_ld(1'b1, 32'hff, 2'b00, 1'b0);
    step("ld_b_ff", 1'b0, 1'b1, 32'hff, 32'h0, 1'b0);
    set_ld(1'b1, 32'hfe, 2'b01, 1'b1);
    step("ld_h_fe", 1'b0, 1'b1, 32'hfe, 32'h0, 1'b0);
    set_ld(1'b1, 32'h100, 2'b00, 1'b0);
    step("ld_b_100", 1'b0, 1'b1, 32'h100, 32'h0, 1'b1);
    set_ld(1'b1, 32'hfffffffc, 2'b10, 1'b0);
    step("ld_w_wrap", 1'b0, 1'b1, 32'hfffffffc, 32'h0, 1'b1);
    ld_req = 1'b0;
    if_req = 1'b1; if_addr = 32'hfe;
    step("if_fe", 1'b1, 1'b0, 32'hfe, 32'h0, 1'b1);
    if_addr = 32'hfc;
    step("if_fc", 1'b1, 1'b0, 32'hfc, 32'h0, 1'b0);
    if_addr = 32'h100;
    step("if_100", 1'b1, 1'b0, 32'h100, 32'h0, 1'b1);
    if_addr = 32'h14;
    step("if_14", 1'b1, 1'b0, 32'h14, 32'hfe114ce3, 1'b0);
    if_req = 1'b0;
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    chk("if_q drained", if_q.size(), 32'd0);
    chk("ld_q drained", ld_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
